// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter sharing the regfile write port
// (WE3/AD3/WD3) between NUM_REQ writeback requesters over valid/ready.
// The winning write is registered and driven to the regfile one cycle
// after acceptance.
// Optional feature macro: WB_ARB_ZERO_GUARD_EN -- writes to address 0 are
// accepted but suppressed at the regfile so x0 stays constant.
module regfile_wb_arbiter #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REQ       = 2,
  localparam int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic                              wb_stall,
  output logic                              we3,
  output logic [ADDRESS_WIDTH-1:0]          ad3,
  output logic [DATA_WIDTH-1:0]             wd3,
  output logic [ID_W-1:0]                   grant_id,
  output logic                              conflict
);

  logic [ID_W-1:0]          r_rr_ptr;
  logic                     r_we3;
  logic [ADDRESS_WIDTH-1:0] r_ad3;
  logic [DATA_WIDTH-1:0]    r_wd3;
  logic [ID_W-1:0]          r_grant_id;
  logic                     r_conflict;

  logic                     w_found;
  logic [ID_W-1:0]          w_win;
  logic                     w_accept;
  logic [ADDRESS_WIDTH-1:0] w_win_addr;
  logic [DATA_WIDTH-1:0]    w_win_data;
  logic [ID_W-1:0]          w_rr_next;
  logic                     w_we_next;
  logic                     w_multi;

  // Round-robin search: first valid index at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    w_found = 1'b0;
    w_win   = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = ID_W'(idx);
      end
    end
  end

  // Grant is suppressed by stall and held off entirely while in reset.
  assign w_accept   = w_found & ~wb_stall & rst_n;
  assign req_ready  = w_accept ? (NUM_REQ'(1) << w_win) : '0;
  assign w_win_addr = req_addr[w_win*ADDRESS_WIDTH +: ADDRESS_WIDTH];
  assign w_win_data = req_data[w_win*DATA_WIDTH +: DATA_WIDTH];
  assign w_rr_next  = (w_win == ID_W'(NUM_REQ-1)) ? '0 : w_win + ID_W'(1);
  assign w_multi    = ($countones(req_valid) >= 2);

`ifdef WB_ARB_ZERO_GUARD_EN
  // x0 is hardwired: the handshake completes but the write is dropped.
  assign w_we_next = (w_win_addr != '0);
`else
  assign w_we_next = 1'b1;
`endif

  // Output stage and pointer: load on acceptance, else only clear we3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_we3      <= 1'b0;
      r_ad3      <= '0;
      r_wd3      <= '0;
      r_grant_id <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= w_accept & w_multi;
      if (w_accept) begin
        r_we3      <= w_we_next;
        r_ad3      <= w_win_addr;
        r_wd3      <= w_win_data;
        r_grant_id <= w_win;
        r_rr_ptr   <= w_rr_next;
      end else begin
        r_we3      <= 1'b0;
      end
    end
  end

  assign we3      = r_we3;
  assign ad3      = r_ad3;
  assign wd3      = r_wd3;
  assign grant_id = r_grant_id;
  assign conflict = r_conflict;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (NUM_REQ=2, default widths).
module tb_regfile_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            wb_stall;
  logic            we3;
  logic [AW-1:0]   ad3;
  logic [DW-1:0]   wd3;
  logic [0:0]      grant_id;
  logic            conflict;

  int total = 0;
  int bad   = 0;

  regfile_wb_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .wb_stall(wb_stall),
    .we3(we3), .ad3(ad3), .wd3(wd3), .grant_id(grant_id), .conflict(conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  logic exp_zero_we;

  initial begin
`ifdef WB_ARB_ZERO_GUARD_EN
    exp_zero_we = 1'b0;
`else
    exp_zero_we = 1'b1;
`endif
    rst_n = 1'b0; wb_stall = 1'b0;
    req_valid = 2'b01; req_addr = '0; req_data = '0;
    #2;
    // Reset state, including ready held low despite a valid request.
    chk("rst_we3",   64'(we3), 64'(0));
    chk("rst_ad3",   64'(ad3), 64'(0));
    chk("rst_wd3",   64'(wd3), 64'(0));
    chk("rst_gid",   64'(grant_id), 64'(0));
    chk("rst_conf",  64'(conflict), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(0));
    edge1();
    edge1();
    rst_n = 1'b1; req_valid = 2'b00;
    for (int c = 0; c < 10; c++) begin
      edge1();
      chk("idle_we3", 64'(we3), 64'(0));
    end

    // Single request from requester 0.
    set_req(0, 5'd5, 32'hDEADBEEF);
    req_valid = 2'b01;
    #1;
    chk("s0_ready", 64'(req_ready), 64'(2'b01));
    edge1();
    req_valid = 2'b00;
    chk("s0_we3", 64'(we3), 64'(1));
    chk("s0_ad3", 64'(ad3), 64'(5));
    chk("s0_wd3", 64'(wd3), 64'h0DEADBEEF);
    chk("s0_gid", 64'(grant_id), 64'(0));
    chk("s0_conf", 64'(conflict), 64'(0));
    edge1();
    chk("s0_we3_off", 64'(we3), 64'(0));
    chk("s0_ad3_hold", 64'(ad3), 64'(5));

    // Single request from requester 1 (rr_ptr is 1 now).
    set_req(1, 5'd3, 32'h0000A5A5);
    req_valid = 2'b10;
    #1;
    chk("s1_ready", 64'(req_ready), 64'(2'b10));
    edge1();
    chk("s1_we3", 64'(we3), 64'(1));
    chk("s1_ad3", 64'(ad3), 64'(3));
    chk("s1_wd3", 64'(wd3), 64'h0A5A5);
    chk("s1_gid", 64'(grant_id), 64'(1));

    // Contention: both valid, rr_ptr back to 0 -> grants 0,1,0,1.
    set_req(0, 5'd10, 32'h100);
    set_req(1, 5'd11, 32'h200);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("ct_ready", 64'(req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
      edge1();
      chk("ct_we3",  64'(we3), 64'(1));
      chk("ct_gid",  64'(grant_id), 64'(i % 2));
      chk("ct_ad3",  64'(ad3), (i % 2 == 0) ? 64'd10 : 64'd11);
      chk("ct_wd3",  64'(wd3), (i % 2 == 0) ? 64'h100 : 64'h200);
      chk("ct_conf", 64'(conflict), 64'(1));
    end

    // Stall for 3 cycles: in-flight write from requester 1 still visible.
    wb_stall = 1'b1;
    #1;
    chk("st_inflight_we3", 64'(we3), 64'(1));
    chk("st_ready", 64'(req_ready), 64'(0));
    for (int c = 0; c < 3; c++) begin
      edge1();
      chk("st_we3",   64'(we3), 64'(0));
      chk("st_conf",  64'(conflict), 64'(0));
      chk("st_ready2", 64'(req_ready), 64'(0));
    end
    wb_stall = 1'b0;
    #1;
    chk("st_rel_ready", 64'(req_ready), 64'(2'b01));
    edge1();
    req_valid = 2'b00;
    chk("st_rel_gid", 64'(grant_id), 64'(0));
    chk("st_rel_ad3", 64'(ad3), 64'(10));
    chk("st_rel_conf", 64'(conflict), 64'(1));

    // Reset mid-flight: accepted write to x7 discarded before commit.
    set_req(1, 5'd7, 32'h1234);
    req_valid = 2'b10;
    #1;
    chk("rm_ready", 64'(req_ready), 64'(2'b10));
    edge1();
    chk("rm_we3", 64'(we3), 64'(1));
    chk("rm_ad3", 64'(ad3), 64'(7));
    set_req(0, 5'd8, 32'h77);
    req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    chk("rm_rst_we3", 64'(we3), 64'(0));
    chk("rm_rst_ready", 64'(req_ready), 64'(0));
    chk("rm_rst_ad3", 64'(ad3), 64'(0));
    edge1();
    chk("rm_rst_we3b", 64'(we3), 64'(0));
    rst_n = 1'b1;
    #1;
    chk("rm_rel_ready", 64'(req_ready), 64'(2'b01));
    edge1();
    chk("rm_g0_gid", 64'(grant_id), 64'(0));
    chk("rm_g0_ad3", 64'(ad3), 64'(8));
    chk("rm_g0_conf", 64'(conflict), 64'(1));
    req_valid = 2'b10;
    #1;
    chk("rm_g1_ready", 64'(req_ready), 64'(2'b10));
    edge1();
    req_valid = 2'b00;
    chk("rm_g1_we3", 64'(we3), 64'(1));
    chk("rm_g1_gid", 64'(grant_id), 64'(1));
    chk("rm_g1_ad3", 64'(ad3), 64'(7));
    chk("rm_g1_wd3", 64'(wd3), 64'h1234);
    chk("rm_g1_conf", 64'(conflict), 64'(0));
    edge1();
    chk("rm_done_we3", 64'(we3), 64'(0));

    // Address 0 write (suppressed only with the zero guard).
    set_req(0, 5'd0, 32'hFFFF);
    req_valid = 2'b01;
    #1;
    chk("z_ready", 64'(req_ready), 64'(2'b01));
    edge1();
    req_valid = 2'b00;
    chk("z_we3", 64'(we3), 64'(exp_zero_we));
    chk("z_ad3", 64'(ad3), 64'(0));
    chk("z_wd3", 64'(wd3), 64'hFFFF);
    chk("z_gid", 64'(grant_id), 64'(0));
    edge1();
    chk("z_we3_off", 64'(we3), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
